// File: rtl/constraint_solve_scheduler.sv
// Shared-LFSR constrained random value scheduler: round-robin grant, redraw until in range.
// Optional macro CONSTRAINT_SCHED_FALLBACK_EN: on exhaustion return the lower bound instead of failing.
module constraint_solve_scheduler #(
    parameter int          NUM_REQ   = 4,
    parameter int          WIDTH     = 16,
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_min,
    input  logic [NUM_REQ*WIDTH-1:0]     req_max,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]             rsp_value,
    output logic                         rsp_fail
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, DRAW, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      lfsr;
    logic [WIDTH-1:0] cand;
    logic [IDW-1:0]   last_grant;
    logic [IDW:0]     start;
    logic [IDW:0]     off;
    logic [IDW:0]     gsum;
    logic [IDW-1:0]   gnt;
    logic [NUM_REQ-1:0] rot;
    logic             found;
    logic             accept;
    logic             contra;
    logic [WIDTH-1:0] sel_min;
    logic [WIDTH-1:0] sel_max;
    logic [WIDTH-1:0] bnd_min;
    logic [WIDTH-1:0] bnd_max;
    logic [7:0]       tries;
    logic             hit;
    logic             last_try;
    logic [WIDTH-1:0] exh_value;
    logic             exh_fail;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign cand = lfsr[WIDTH-1:0];

    // Round-robin search: rotate so last_grant+1 sits at bit 0, pick lowest set bit
    always_comb begin
        start = (last_grant == IDW'(NUM_REQ-1)) ? '0 : {1'b0, last_grant} + (IDW+1)'(1);
        rot   = NUM_REQ'({req_valid, req_valid} >> start);
        found = 1'b0;
        off   = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = (IDW+1)'(i);
            end
        end
        gsum = start + off;
        if (gsum >= (IDW+1)'(NUM_REQ)) begin
            gsum = gsum - (IDW+1)'(NUM_REQ);
        end
        gnt = gsum[IDW-1:0];
    end

    always_comb begin
        sel_min = '0;
        sel_max = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == IDW'(i)) begin
                sel_min = req_min[i*WIDTH +: WIDTH];
                sel_max = req_max[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept    = (state == IDLE) && found;
    assign contra    = sel_min > sel_max;
    assign req_ready = accept ? (NUM_REQ'(1) << gnt) : '0;
    assign hit       = (cand >= bnd_min) && (cand <= bnd_max);
    assign last_try  = (tries == 8'(MAX_TRIES-1));
    assign rsp_valid = (state == RESP);

`ifdef CONSTRAINT_SCHED_FALLBACK_EN
    assign exh_value = bnd_min;
    assign exh_fail  = 1'b0;
`else
    assign exh_value = '0;
    assign exh_fail  = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = contra ? RESP : DRAW;
                end
            end
            DRAW: begin
                if (hit || last_try) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NUM_REQ-1);
            tries      <= '0;
            rsp_id     <= '0;
            rsp_value  <= '0;
            rsp_fail   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= gnt;
                rsp_id     <= gnt;
                tries      <= '0;
                if (contra) begin
                    rsp_value <= '0;
                    rsp_fail  <= 1'b1;
                end
            end else if (state == DRAW) begin
                if (hit) begin
                    rsp_value <= cand;
                    rsp_fail  <= 1'b0;
                end else begin
                    tries <= tries + 8'd1;
                    if (last_try) begin
                        rsp_value <= exh_value;
                        rsp_fail  <= exh_fail;
                    end
                end
            end
        end
    end

    // Bounds are captured at accept; later changes by the requester are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            bnd_min <= sel_min;
            bnd_max <= sel_max;
        end
    end

endmodule

// File: tb/tb_constraint_solve_scheduler.sv
// Directed bench for constraint_solve_scheduler: vector table plus multi-cycle sequences.
module tb_constraint_solve_scheduler;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_min;
    logic [N*W-1:0]   req_max;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_value;
    logic             rsp_fail;

    int errors = 0;
    int checks = 0;
    int last_g = N - 1;

    constraint_solve_scheduler #(
        .NUM_REQ(N), .WIDTH(W), .MAX_TRIES(MT), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_min(req_min), .req_max(req_max),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_value(rsp_value), .rsp_fail(rsp_fail)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    logic [15:0] m_lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; issues one request and completes its response.
    task automatic run_req(input int id, input logic [15:0] mn, input logic [15:0] mx,
                           output logic [15:0] got);
        logic [15:0] s;
        logic [15:0] ev;
        logic        ef;
        int          el;
        int          c;
        s  = m_lfsr;
        el = 1 + MT;
`ifdef CONSTRAINT_SCHED_FALLBACK_EN
        ev = mn; ef = 1'b0;
`else
        ev = 16'h0; ef = 1'b1;
`endif
        if (mn > mx) begin
            el = 1; ev = 16'h0; ef = 1'b1;
        end else begin
            for (int k = 1; k <= MT; k++) begin
                s = lfsr_next(s);
                if (s >= mn && s <= mx) begin
                    el = 1 + k; ev = s; ef = 1'b0;
                    break;
                end
            end
        end
        req_min[id*W +: W] = mn;
        req_max[id*W +: W] = mx;
        req_valid[id] = 1'b1;
        #1;
        check("accept_ready", 32'(req_ready), 32'(1) << id);
        for (c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = '0;
                req_min[id*W +: W] = ~mn;
                req_max[id*W +: W] = ~mx;
            end
            if (rsp_valid) break;
        end
        check("latency", 32'(c), 32'(el));
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_value", 32'(rsp_value), 32'(ev));
        check("rsp_fail", 32'(rsp_fail), 32'(ef));
        got = rsp_value;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", 32'(rsp_valid), 32'd0);
        last_g = id;
    endtask

    typedef struct {
        int          id;
        logic [15:0] mn;
        logic [15:0] mx;
    } vec_t;

    vec_t        vecs[8];
    logic [15:0] got;
    logic [1:0]  hid;
    logic [15:0] hval;
    logic [N-1:0] prev_rdy;
    int          exp_g, exp_r, grants, resps, c;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 16'h0000, 16'hFFFF};
        vecs[1] = '{2, 16'h0005, 16'h0003};
        vecs[2] = '{1, 16'h1234, 16'h1234};
        vecs[3] = '{3, 16'h0000, 16'h7FFF};
        vecs[4] = '{0, 16'hFFF0, 16'hFFFF};
        vecs[5] = '{2, 16'h8000, 16'hFFFF};
        vecs[6] = '{3, 16'h4000, 16'h4000};
        vecs[7] = '{0, 16'h2000, 16'h9FFF};

        rst = 1'b1; req_valid = '0; req_min = '0; req_max = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_value", 32'(rsp_value), 32'd0);
        check("reset_rsp_fail", 32'(rsp_fail), 32'd0);
        rst = 1'b0;

        // First draw after reset sees the second LFSR state
        run_req(0, 16'h0000, 16'hFFFF, got);
        check("first_value", 32'(got), 32'h5670);

        for (int v = 0; v < 8; v++) begin
            run_req(vecs[v].id, vecs[v].mn, vecs[v].mx, got);
        end

        // Response held while the consumer stalls; no accepts meanwhile
        req_min[1*W +: W] = 16'h0000; req_max[1*W +: W] = 16'hFFFF;
        req_valid[1] = 1'b1;
        #1;
        check("hold_accept", 32'(req_ready), 32'b0010);
        for (c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = '0;
            if (rsp_valid) break;
        end
        check("hold_latency", 32'(c), 32'd2);
        hid = rsp_id; hval = rsp_value;
        req_min[2*W +: W] = 16'h0000; req_max[2*W +: W] = 16'hFFFF;
        req_valid[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_id", 32'(rsp_id), 32'(hid));
            check("hold_value", 32'(rsp_value), 32'(hval));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        last_g = 1;

        // Reset in the middle of a draw that can never hit (LFSR is never zero)
        req_min[2*W +: W] = 16'h0000; req_max[2*W +: W] = 16'h0000;
        req_valid[2] = 1'b1;
        #1;
        check("mid_accept", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        check("mid_drawing", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_id", 32'(rsp_id), 32'd0);
        check("mid_rst_value", 32'(rsp_value), 32'd0);
        check("mid_rst_fail", 32'(rsp_fail), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_g = N - 1;
        req_min[2*W +: W] = 16'h0000; req_max[2*W +: W] = 16'hFFFF;
        req_valid[2] = 1'b1;
        run_req(0, 16'h0000, 16'hFFFF, got);
        check("post_rst_value", 32'(got), 32'h5670);

        run_req(3, 16'h0000, 16'hFFFF, got);

        // All requesters valid, consumer always ready: grants rotate
        for (int i = 0; i < N; i++) begin
            req_min[i*W +: W] = 16'h0000;
            req_max[i*W +: W] = 16'hFFFF;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        exp_g = (last_g + 1) % N;
        exp_r = exp_g;
        grants = 0; resps = 0; prev_rdy = '0;
        #1;
        for (int cyc = 0; cyc < 60 && resps < 5; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (grants == 5) req_valid = '0;
                #1;
            end
            if (prev_rdy != '0) check("rot_pulse_width", 32'(req_ready), 32'd0);
            if (req_ready != '0) begin
                check("rot_grant", 32'(req_ready), 32'(1) << exp_g);
                exp_g = (exp_g + 1) % N;
                grants++;
            end
            if (rsp_valid) begin
                check("rot_rsp_id", 32'(rsp_id), 32'(exp_r));
                exp_r = (exp_r + 1) % N;
                resps++;
            end
            prev_rdy = req_ready;
        end
        check("rot_responses", 32'(resps), 32'd5);
        check("rot_grants", 32'(grants), 32'd5);
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
